// File: rtl/rs_issue_queue_pkg.sv
// Shared types for the reservation station: issue packet, bubble constant and execute-stage encodings.
// PRF tag width comes from the `PRF_width macro and falls back to 6 bits when it is not defined.
`ifndef PRF_width
`define PRF_width 6
`endif

package rs_issue_queue_pkg;

   localparam int PRF_W = `PRF_width;

   typedef enum logic [4:0] {
      ALU_ADDQ   = 5'h00,
      ALU_SUBQ   = 5'h01,
      ALU_AND    = 5'h02,
      ALU_BIC    = 5'h03,
      ALU_BIS    = 5'h04,
      ALU_ORNOT  = 5'h05,
      ALU_XOR    = 5'h06,
      ALU_EQV    = 5'h07,
      ALU_SRL    = 5'h08,
      ALU_SLL    = 5'h09,
      ALU_SRA    = 5'h0a,
      ALU_MULQ   = 5'h0b,
      ALU_CMPEQ  = 5'h0c,
      ALU_CMPLT  = 5'h0d,
      ALU_CMPLE  = 5'h0e,
      ALU_CMPULT = 5'h0f,
      ALU_CMPULE = 5'h10
   } alu_func_t;

   typedef enum logic [1:0] {
      ALU_OPA_IS_REGA     = 2'h0,
      ALU_OPA_IS_MEM_DISP = 2'h1,
      ALU_OPA_IS_NPC      = 2'h2,
      ALU_OPA_IS_NOT3     = 2'h3
   } alu_opa_t;

   typedef enum logic [1:0] {
      ALU_OPB_IS_REGB    = 2'h0,
      ALU_OPB_IS_ALU_IMM = 2'h1,
      ALU_OPB_IS_BR_DISP = 2'h2
   } alu_opb_t;

   typedef struct packed {
      alu_func_t        opcode;
      alu_opa_t         opa_select;
      alu_opb_t         opb_select;
      logic [31:0]      inst;
      logic [63:0]      npc;
      logic [63:0]      pred_target;
      logic             cond_branch;
      logic             uncond_branch;
      logic             rd_mem;
      logic             wr_mem;
      logic             ldl_mem;
      logic             stc_mem;
      logic             cpuid;
      logic [PRF_W-1:0] src_a;
      logic [PRF_W-1:0] src_b;
      logic [PRF_W-1:0] dest;
   } rs_pkt_t;

   localparam rs_pkt_t RS_BUBBLE = '{
      opcode:        ALU_ADDQ,
      opa_select:    ALU_OPA_IS_REGA,
      opb_select:    ALU_OPB_IS_REGB,
      inst:          32'h0,
      npc:           64'h0,
      pred_target:   64'h0,
      cond_branch:   1'b0,
      uncond_branch: 1'b0,
      rd_mem:        1'b0,
      wr_mem:        1'b0,
      ldl_mem:       1'b0,
      stc_mem:       1'b0,
      cpuid:         1'b0,
      src_a:         '0,
      src_b:         '0,
      dest:          '0
   };

   function automatic logic is_mulq(input rs_pkt_t p);
      return p.opcode == ALU_MULQ;
   endfunction

endpackage

// File: rtl/rs_issue_queue_select.sv
// Combinational picker: one-hot grant to the requester with the largest age, lowest index on ties.
// With all ages tied at zero it degenerates to plain lowest-index priority.
module rs_issue_queue_select
   import rs_issue_queue_pkg::*;
#(
   parameter int N     = 8,
   parameter int AGE_W = 3
) (
   input  logic [N-1:0]            req,
   input  logic [N-1:0][AGE_W-1:0] age,
   output logic [N-1:0]            gnt,
   output logic                    gnt_valid
);

   logic [AGE_W-1:0] best_age;

   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      best_age  = '0;
      for (int i = 0; i < N; i++) begin
         // strict compare keeps the earlier index on equal age
         if (req[i] && (!gnt_valid || (age[i] > best_age))) begin
            gnt       = '0;
            gnt[i]    = 1'b1;
            gnt_valid = 1'b1;
            best_age  = age[i];
         end
      end
   end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station feeding the execute-stage issue register; CDB wakeup, mult/stall back-pressure, flush.
// Define RS_AGE_SELECT_EN to pick the oldest eligible entry instead of the lowest index.
module rs_issue_queue
   import rs_issue_queue_pkg::*;
#(
   parameter int RS_ENTRIES = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            disp_valid_in,
   input  rs_pkt_t                         disp_pkt_in,
   input  logic                            disp_srcA_ready_in,
   input  logic                            disp_srcB_ready_in,
   input  logic [PRF_W-1:0]                ex_CDB_tag_in,
   input  logic                            ex_CDB_arb_stall_in,
   input  logic                            ex_MULT_busy_in,
   input  logic                            ROB_branch_mispredict_in,
   output logic                            rs_full_out,
   output logic [$clog2(RS_ENTRIES):0]     rs_free_cnt_out,
   output rs_pkt_t                         rs_ex_pkt_out
);

   localparam int CNT_W = $clog2(RS_ENTRIES) + 1;
   localparam int AGE_W = $clog2(RS_ENTRIES);

   logic [RS_ENTRIES-1:0] valid_q, valid_d;
   logic [RS_ENTRIES-1:0] rdy_a_q, rdy_a_d;
   logic [RS_ENTRIES-1:0] rdy_b_q, rdy_b_d;
   rs_pkt_t               pkt_q [RS_ENTRIES];
   rs_pkt_t               pkt_d [RS_ENTRIES];
   rs_pkt_t               ex_pkt_q, ex_pkt_d;
   logic [CNT_W-1:0]      free_cnt_q, free_cnt_d;
   logic                  rs_full_q, rs_full_d;

   logic [RS_ENTRIES-1:0]            elig;
   logic [RS_ENTRIES-1:0]            iss_gnt;
   logic                             iss_valid;
   logic [RS_ENTRIES-1:0]            free_gnt;
   logic                             free_valid;
   logic [RS_ENTRIES-1:0][AGE_W-1:0] age_sel;
   rs_pkt_t                          iss_pkt;
   logic                             cdb_hit;
   logic                             disp_rdy_a;
   logic                             disp_rdy_b;
   logic                             disp_accept;
   logic                             issue_fire;

   assign cdb_hit    = (ex_CDB_tag_in != '0);
   assign disp_rdy_a = disp_srcA_ready_in || (disp_pkt_in.src_a == '0) ||
                       (cdb_hit && (disp_pkt_in.src_a == ex_CDB_tag_in));
   assign disp_rdy_b = disp_srcB_ready_in || (disp_pkt_in.src_b == '0) ||
                       (cdb_hit && (disp_pkt_in.src_b == ex_CDB_tag_in));

   // free-slot search works off registered occupancy, so a slot vacated by issue waits a cycle
   assign disp_accept = disp_valid_in && !rs_full_q && free_valid && !ROB_branch_mispredict_in;
   assign issue_fire  = iss_valid && !ex_CDB_arb_stall_in && !ROB_branch_mispredict_in;

   always_comb begin
      elig = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         elig[i] = valid_q[i] && rdy_a_q[i] && rdy_b_q[i] &&
                   !(is_mulq(pkt_q[i]) && ex_MULT_busy_in);
      end
   end

`ifdef RS_AGE_SELECT_EN
   logic [RS_ENTRIES-1:0][AGE_W-1:0] age_q, age_d;

   assign age_sel = age_q;

   always_comb begin
      age_d = age_q;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (disp_accept && free_gnt[i]) begin
            age_d[i] = '0;
         end else if (valid_q[i] && (age_q[i] != '1)) begin
            age_d[i] = age_q[i] + AGE_W'(1);
         end
      end
      if (ROB_branch_mispredict_in) begin
         age_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   assign age_sel = '0;
`endif

   rs_issue_queue_select #(.N(RS_ENTRIES), .AGE_W(AGE_W)) u_issue_sel (
      .req       (elig),
      .age       (age_sel),
      .gnt       (iss_gnt),
      .gnt_valid (iss_valid)
   );

   rs_issue_queue_select #(.N(RS_ENTRIES), .AGE_W(AGE_W)) u_free_sel (
      .req       (~valid_q),
      .age       ('0),
      .gnt       (free_gnt),
      .gnt_valid (free_valid)
   );

   always_comb begin
      iss_pkt = RS_BUBBLE;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (iss_gnt[i]) begin
            iss_pkt = pkt_q[i];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      rdy_a_d = rdy_a_q;
      rdy_b_d = rdy_b_q;
      pkt_d   = pkt_q;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         if (valid_q[i] && cdb_hit && (pkt_q[i].src_a == ex_CDB_tag_in)) begin
            rdy_a_d[i] = 1'b1;
         end
         if (valid_q[i] && cdb_hit && (pkt_q[i].src_b == ex_CDB_tag_in)) begin
            rdy_b_d[i] = 1'b1;
         end
         if (issue_fire && iss_gnt[i]) begin
            valid_d[i] = 1'b0;
         end
         if (disp_accept && free_gnt[i]) begin
            valid_d[i] = 1'b1;
            pkt_d[i]   = disp_pkt_in;
            rdy_a_d[i] = disp_rdy_a;
            rdy_b_d[i] = disp_rdy_b;
         end
      end
      if (ROB_branch_mispredict_in) begin
         valid_d = '0;
      end
   end

   always_comb begin
      if (ROB_branch_mispredict_in) begin
         ex_pkt_d   = RS_BUBBLE;
         free_cnt_d = CNT_W'(RS_ENTRIES);
      end else begin
         ex_pkt_d   = ex_CDB_arb_stall_in ? ex_pkt_q : iss_pkt;
         free_cnt_d = free_cnt_q + CNT_W'(issue_fire) - CNT_W'(disp_accept);
      end
      rs_full_d = (free_cnt_d == '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q    <= '0;
         rdy_a_q    <= '0;
         rdy_b_q    <= '0;
         ex_pkt_q   <= RS_BUBBLE;
         free_cnt_q <= CNT_W'(RS_ENTRIES);
         rs_full_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rdy_a_q    <= rdy_a_d;
         rdy_b_q    <= rdy_b_d;
         ex_pkt_q   <= ex_pkt_d;
         free_cnt_q <= free_cnt_d;
         rs_full_q  <= rs_full_d;
      end
   end

   // payload is qualified by valid_q, so it needs no reset
   always_ff @(posedge clock) begin
      pkt_q <= pkt_d;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(disp_valid_in && rs_full_q))
            else $warning("rs_issue_queue: dispatch dropped, queue full");
      end
   end
`endif

   assign rs_ex_pkt_out   = ex_pkt_q;
   assign rs_free_cnt_out = free_cnt_q;
   assign rs_full_out     = rs_full_q;

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Reservation station directly upstream of the execute stage; the execute stage's PRF read ports, ALU, multiplier and CDB arbiter consume its output register.
- Holds up to RS_ENTRIES dispatched instructions and wakes sources on CDB tag matches.
- Selects one ready instruction per cycle into a registered rs_ex_* packet; honours execute-stage multiplier busy and CDB stall back-pressure; flushes on branch mispredict.

Parameters:
- RS_ENTRIES, 8, number of entries (power of two, 4..16)
- PRF_W, `PRF_width, physical register tag width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- disp_valid_in  in  1  dispatch request this cycle
- disp_pkt_in  in  rs_pkt_t  opcode, opa/opb select, IR, PC_plus_4, predicted target, branch/ld/st/ldl/stc/cpuid flags, srcA/srcB/dest tags
- disp_srcA_ready_in  in  1  srcA value already in PRF
- disp_srcB_ready_in  in  1  srcB value already in PRF
- ex_CDB_tag_in  in  PRF_W  tag broadcast by execute this cycle; 0 means none
- ex_CDB_arb_stall_in  in  1  execute could not retire its current packet
- ex_MULT_busy_in  in  1  multiplier occupied
- ROB_branch_mispredict_in  in  1  flush
- rs_full_out  out  1  no free entry (registered)
- rs_free_cnt_out  out  $clog2(RS_ENTRIES)+1  free entries (registered)
- rs_ex_pkt_out  out  rs_pkt_t  issue register to execute; bubble = all flags 0, opcode `ALU_ADDQ, all tags 0

Behaviour:
- Reset: all entries invalid; rs_ex_pkt_out = bubble; rs_full_out = 0; rs_free_cnt_out = RS_ENTRIES.
- Entry state: valid, pkt, rdyA, rdyB.
- Tag 0 is always ready: rdy = srcX_ready_in | (tag==0).
- Wakeup: every cycle, any valid entry with srcX tag == ex_CDB_tag_in != 0 sets rdyX.
- Dispatch bypass: an entry dispatched in the same cycle as a matching CDB tag is written ready.
- Dispatch:
  - Writes the lowest-index invalid entry, using registered occupancy.
  - disp_valid_in while rs_full_out is high is dropped and fires an assertion.
  - An entry freed by issue is not reusable until the next cycle.
- Eligibility: valid & rdyA & rdyB & !(opcode==`ALU_MULQ & ex_MULT_busy_in).
- Select: lowest-index eligible entry (see feature).
- Issue register update, priority per cycle:
  1. ROB_branch_mispredict_in: all entries invalid, rs_ex_pkt_out <= bubble, dispatch that cycle ignored.
  2. ex_CDB_arb_stall_in: rs_ex_pkt_out holds, no entry leaves; wakeup and dispatch still occur.
  3. Otherwise: rs_ex_pkt_out <= selected entry and that entry invalidates. If none is eligible, rs_ex_pkt_out <= bubble.
- Latency:
  - Dispatch with both sources ready → earliest on rs_ex_pkt_out next cycle +1 (written at edge N, selected N, registered N+1).
  - Wakeup at edge N allows issue registration at N+1.
- Counters: rs_free_cnt_out updates as +1 per issue, −1 per accepted dispatch, simultaneous = unchanged, flush = RS_ENTRIES. rs_full_out = (next count==0), registered.

Optional Feature:
- RS_AGE_SELECT_EN
  - Defined: each entry carries an age counter of width $clog2(RS_ENTRIES). The value is 0 on dispatch and increments on each non-flush cycle it remains, saturating. Select picks the maximum-age eligible entry, with the lower index winning ties.
  - Undefined: no age storage; pure lowest-index priority.

Decomposition:
- Shared package: rs_pkt_t struct, RS_BUBBLE constant, and the ALU opcode and opa/opb select encodings already used by execute.
- One sub-module, rs_select: combinational priority/age picker returning a one-hot grant and a valid flag. It serves both dispatch free-slot search and issue select.

Test Plan:
- Reset, then dispatch ADDQ with src tags 0, dest 5 → issued the next cycle: rs_ex_pkt_out.dest=5, then bubble; rs_free_cnt_out back to 8.
- Dispatch srcA=12 not ready; drive ex_CDB_tag_in=12 two cycles later → issue registered the cycle after the wakeup, not before.
- Dispatch with srcB=9 while ex_CDB_tag_in=9 the same cycle → entry written ready and issued the next cycle.
- Two MULQ entries ready, ex_MULT_busy_in=1 → neither issues and an eligible ADDQ in entry 3 issues; drop busy → MULQ in entry 0 issues.
- Fill 8 entries with unready sources → rs_full_out=1, count 0; 9th dispatch dropped with the assertion firing; wake one → issue, full clears the following cycle.
- Issue pending with ex_CDB_arb_stall_in=1 for 3 cycles → rs_ex_pkt_out stable; assert ROB_branch_mispredict_in → all entries invalid, bubble out, count 8.
